// File: rtl/mc_exec_pkg.sv
// Shared definitions for the MC execute stage.
// Holds the opcode encoding, FSM state encoding, register addresses and
// the default datapath widths and saturation magnitude.
package mc_exec_pkg;

   localparam int unsigned DATA_W  = 11;
   localparam int unsigned SLEEP_W = 10;
   localparam int unsigned MAX_VAL = 999;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned ADDR_W  = 3;

   localparam logic [OP_W-1:0] OP_NOP = 4'd0;
   localparam logic [OP_W-1:0] OP_MOV = 4'd1;
   localparam logic [OP_W-1:0] OP_ADD = 4'd2;
   localparam logic [OP_W-1:0] OP_SUB = 4'd3;
   localparam logic [OP_W-1:0] OP_MUL = 4'd4;
   localparam logic [OP_W-1:0] OP_NOT = 4'd5;
   localparam logic [OP_W-1:0] OP_TEQ = 4'd6;
   localparam logic [OP_W-1:0] OP_TGT = 4'd7;
   localparam logic [OP_W-1:0] OP_TLT = 4'd8;
   localparam logic [OP_W-1:0] OP_TCP = 4'd9;
   localparam logic [OP_W-1:0] OP_SLP = 4'd10;

   localparam logic [ADDR_W-1:0] ADDR_ACC = 3'b000;
   localparam logic [ADDR_W-1:0] ADDR_P0  = 3'b010;
   localparam logic [ADDR_W-1:0] ADDR_P1  = 3'b011;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SLEEP = 1'b1
   } state_e;

endpackage

// File: rtl/mc_exec_if.sv
// Instruction handshake and register-file write bus of the execute stage.
// master: fetch/decode side driving instructions and receiving writes.
// slave : execute stage accepting instructions and driving the write port.
interface mc_exec_if
   import mc_exec_pkg::*;
#(
   parameter int unsigned W = DATA_W
);
   logic                 instr_valid;
   logic                 instr_ready;
   logic [OP_W-1:0]      opcode;
   logic [ADDR_W-1:0]    dst_addr;
   logic signed [W-1:0]  src_a;
   logic signed [W-1:0]  src_b;
   logic signed [W-1:0]  write_dat;
   logic [ADDR_W-1:0]    write_addr;
   logic                 write_en;

   modport master (
      output instr_valid, opcode, dst_addr, src_a, src_b,
      input  instr_ready, write_dat, write_addr, write_en
   );

   modport slave (
      input  instr_valid, opcode, dst_addr, src_a, src_b,
      output instr_ready, write_dat, write_addr, write_en
   );
endinterface

// File: rtl/mc_exec_unit_sat.sv
// Signed clamp of an IN_W-bit value to [-MAX_VAL, +MAX_VAL], truncated to W bits.
// Ports: din (IN_W signed), dout_c (W signed, combinational).
module mc_sat_clamp
   import mc_exec_pkg::*;
#(
   parameter int unsigned IN_W    = DATA_W + 1,
   parameter int unsigned W       = DATA_W,
   parameter int unsigned MAX_VAL = mc_exec_pkg::MAX_VAL
) (
   input  logic signed [IN_W-1:0] din,
   output logic signed [W-1:0]    dout_c
);
   localparam logic signed [IN_W-1:0] HI = IN_W'(MAX_VAL);
   localparam logic signed [IN_W-1:0] LO = -HI;

   always_comb begin
      if (din > HI)      dout_c = HI[W-1:0];
      else if (din < LO) dout_c = LO[W-1:0];
      else               dout_c = din[W-1:0];
   end
endmodule

// File: rtl/mc_exec_unit.sv
// Execute stage: saturating ALU, +/- condition flags and slp timer.
// Ports: clk, rst_n; bus (instruction handshake in, register-file write out);
// time_tick (time-unit pulse); flag_plus/flag_minus; sleeping.
module mc_exec_unit
   import mc_exec_pkg::*;
#(
   parameter int unsigned W       = DATA_W,
   parameter int unsigned MAX_VAL = mc_exec_pkg::MAX_VAL,
   parameter int unsigned SLP_W   = SLEEP_W
) (
   input  logic         clk,
   input  logic         rst_n,
   mc_exec_if.slave     bus,
   input  logic         time_tick,
   output logic         flag_plus,
   output logic         flag_minus,
   output logic         sleeping
);
   state_e               state_q, state_d;
   logic [SLP_W-1:0]     cnt_q, cnt_d;
   logic                 ready_q, ready_d;
   logic                 sleep_q, sleep_d;
   logic                 wen_q, wen_d;
   logic [ADDR_W-1:0]    waddr_q, waddr_d;
   logic signed [W-1:0]  wdat_q, wdat_d;
   logic                 fp_q, fp_d;
   logic                 fm_q, fm_d;

   logic signed [W-1:0]   a, b;
   logic signed [W:0]     addsub_c;
   logic signed [2*W-1:0] a_mul, b_mul, prod_c;
   logic signed [W-1:0]   addsub_sat_c, mul_sat_c;
   logic                  accept_c;

   // Operand extension: add/sub one guard bit, mul full double width.
   always_comb begin
      a        = bus.src_a;
      b        = bus.src_b;
      addsub_c = (bus.opcode == OP_SUB) ? ({a[W-1], a} - {b[W-1], b})
                                        : ({a[W-1], a} + {b[W-1], b});
      a_mul    = {{W{a[W-1]}}, a};
      b_mul    = {{W{b[W-1]}}, b};
      prod_c   = a_mul * b_mul;
   end

   mc_sat_clamp #(.IN_W(W + 1), .W(W), .MAX_VAL(MAX_VAL)) u_sat_addsub (
      .din    (addsub_c),
      .dout_c (addsub_sat_c)
   );

   mc_sat_clamp #(.IN_W(2 * W), .W(W), .MAX_VAL(MAX_VAL)) u_sat_mul (
      .din    (prod_c),
      .dout_c (mul_sat_c)
   );

   // ready_q is only ever set while in IDLE.
   assign accept_c = bus.instr_valid && ready_q;

   // Next-state, write port and flag logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wen_d   = 1'b0;
      waddr_d = waddr_q;
      wdat_d  = wdat_q;
      fp_d    = fp_q;
      fm_d    = fm_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               case (bus.opcode)
                  OP_MOV: begin
                     wen_d = 1'b1; waddr_d = bus.dst_addr; wdat_d = a;
                  end
                  OP_ADD, OP_SUB: begin
                     wen_d = 1'b1; waddr_d = ADDR_ACC; wdat_d = addsub_sat_c;
                  end
                  OP_MUL: begin
                     wen_d = 1'b1; waddr_d = ADDR_ACC; wdat_d = mul_sat_c;
                  end
                  OP_NOT: begin
                     wen_d   = 1'b1;
                     waddr_d = ADDR_ACC;
                     wdat_d  = (a == '0) ? W'(100) : '0;
                  end
                  OP_TEQ: begin fp_d = (a == b); fm_d = !(a == b); end
                  OP_TGT: begin fp_d = (a > b);  fm_d = !(a > b);  end
                  OP_TLT: begin fp_d = (a < b);  fm_d = !(a < b);  end
                  OP_TCP: begin fp_d = (a > b);  fm_d = (a < b);   end
                  OP_SLP: begin
                     // Only a strictly positive duration stalls the core.
                     if (!a[W-1] && (a != '0)) begin
                        state_d = ST_SLEEP;
                        cnt_d   = SLP_W'(a);
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_SLEEP: begin
            if (time_tick) begin
               cnt_d = cnt_q - SLP_W'(1);
               if (cnt_q == SLP_W'(1)) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
      sleep_d = (state_d == ST_SLEEP);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         sleep_q <= 1'b0;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdat_q  <= '0;
         fp_q    <= 1'b0;
         fm_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         sleep_q <= sleep_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdat_q  <= wdat_d;
         fp_q    <= fp_d;
         fm_q    <= fm_d;
      end
   end

   assign bus.instr_ready = ready_q;
   assign bus.write_en    = wen_q;
   assign bus.write_addr  = waddr_q;
   assign bus.write_dat   = wdat_q;
   assign flag_plus       = fp_q;
   assign flag_minus      = fm_q;
   assign sleeping        = sleep_q;
endmodule

// File: tb/tb_mc_exec_unit.sv
// Directed self-checking bench for mc_exec_unit.
module tb_mc_exec_unit;
   import mc_exec_pkg::*;

   logic clk;
   logic rst_n;
   logic time_tick;
   logic flag_plus, flag_minus, sleeping;
   int   checks;
   int   failures;

   mc_exec_if #(.W(DATA_W)) bus ();

   mc_exec_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .time_tick  (time_tick),
      .flag_plus  (flag_plus),
      .flag_minus (flag_minus),
      .sleeping   (sleeping)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Present one instruction for one edge; outputs are sampled 1ns after it.
   task automatic issue(input logic [3:0] op, input logic [2:0] dst,
                        input int a, input int b);
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.opcode      = op;
      bus.dst_addr    = dst;
      bus.src_a       = 11'(a);
      bus.src_b       = 11'(b);
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.opcode      = OP_NOP;
   endtask

   task automatic check_write(input string tag, input int addr, input int dat);
      check({tag, "_en"}, 32'(bus.write_en), 1);
      check({tag, "_addr"}, 32'(bus.write_addr), addr);
      check({tag, "_dat"}, $signed(bus.write_dat), dat);
   endtask

   initial begin
      checks          = 0;
      failures        = 0;
      rst_n           = 1'b0;
      time_tick       = 1'b0;
      bus.instr_valid = 1'b0;
      bus.opcode      = OP_NOP;
      bus.dst_addr    = '0;
      bus.src_a       = '0;
      bus.src_b       = '0;
      #3;
      check("rst_ready", 32'(bus.instr_ready), 0);
      check("rst_wen", 32'(bus.write_en), 0);
      check("rst_sleeping", 32'(sleeping), 0);
      check("rst_flags", 32'({flag_plus, flag_minus}), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_rst", 32'(bus.instr_ready), 1);

      issue(OP_ADD, 3'd5, 900, 200);
      check_write("add_sat", 0, 999);
      issue(OP_SUB, 3'd0, -900, 200);
      check_write("sub_sat", 0, -999);
      issue(OP_MUL, 3'd0, -40, 30);
      check_write("mul_sat", 0, -999);
      issue(OP_MUL, 3'd0, 12, -11);
      check_write("mul", 0, -132);
      issue(OP_NOT, 3'd0, 0, 0);
      check_write("not0", 0, 100);
      issue(OP_NOT, 3'd0, 5, 0);
      check_write("not5", 0, 0);
      issue(OP_NOP, 3'd0, 1, 1);
      check("nop_wen", 32'(bus.write_en), 0);
      issue(4'd12, 3'd0, 1, 1);
      check("undef_wen", 32'(bus.write_en), 0);

      // Back-to-back MOV then ADD.
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.opcode = OP_MOV; bus.dst_addr = ADDR_P0; bus.src_a = 11'(77); bus.src_b = '0;
      @(posedge clk);
      #1;
      bus.opcode = OP_ADD; bus.src_a = 11'(10); bus.src_b = 11'(-3);
      check_write("mov", 2, 77);
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      check_write("b2b_add", 0, 7);

      issue(OP_TCP, 3'd0, 5, 5);
      check("tcp_eq", 32'({flag_plus, flag_minus}), 0);
      check("tcp_wen", 32'(bus.write_en), 0);
      issue(OP_TGT, 3'd0, 6, 5);
      check("tgt", 32'({flag_plus, flag_minus}), 2);
      issue(OP_TLT, 3'd0, -4, 3);
      check("tlt_signed", 32'({flag_plus, flag_minus}), 2);
      issue(OP_TEQ, 3'd0, 4, 3);
      check("teq_ne", 32'({flag_plus, flag_minus}), 1);
      issue(OP_TGT, 3'd0, 6, 5);
      issue(OP_ADD, 3'd0, 1, 2);
      check_write("add_noflag", 0, 3);
      check("flags_held", 32'({flag_plus, flag_minus}), 2);

      // SLP 3 with a tick every 4 cycles; an ADD waits upstream meanwhile.
      issue(OP_SLP, 3'd0, 3, 0);
      check("slp_sleeping", 32'(sleeping), 1);
      check("slp_ready", 32'(bus.instr_ready), 0);
      bus.instr_valid = 1'b1;
      bus.opcode = OP_ADD; bus.src_a = 11'(10); bus.src_b = 11'(20);
      for (int t = 1; t <= 3; t++) begin
         repeat (3) begin
            @(negedge clk);
            time_tick = 1'b0;
            @(posedge clk);
            #1;
            check("slp_no_write", 32'(bus.write_en), 0);
         end
         @(negedge clk);
         time_tick = 1'b1;
         @(posedge clk);
         #1;
         if (t < 3) begin
            check("slp_still_asleep", 32'({sleeping, bus.instr_ready}), 2);
         end else begin
            check("slp_wake", 32'({sleeping, bus.instr_ready}), 1);
            check("slp_wake_no_write", 32'(bus.write_en), 0);
         end
      end
      @(negedge clk);
      time_tick = 1'b0;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      check_write("held_add", 0, 30);

      issue(OP_SLP, 3'd0, 0, 0);
      check("slp0", 32'({sleeping, bus.instr_ready}), 1);
      issue(OP_SLP, 3'd0, -5, 0);
      check("slpneg", 32'({sleeping, bus.instr_ready}), 1);

      // Reset pulse in the middle of a sleep.
      issue(OP_SLP, 3'd0, 5, 0);
      check("slp5_sleeping", 32'(sleeping), 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_sleeping", 32'(sleeping), 0);
      check("arst_ready", 32'(bus.instr_ready), 0);
      check("arst_wdat", $signed(bus.write_dat), 0);
      check("arst_flags", 32'({flag_plus, flag_minus}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("arst_release_ready", 32'(bus.instr_ready), 1);
      issue(OP_ADD, 3'd0, 100, 23);
      check_write("post_rst_add", 0, 123);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
